// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Computes WIDTH-bit additions on one shared 4-bit nibble adder. An operand
//   pair is accepted over a valid/ready handshake, added LSB nibble first over
//   WIDTH/4 cycles with the carry chained through a register, and the sum and
//   final carry are returned over a second valid/ready handshake.
//
//   Optional feature macro: SUB_EN
//     When defined, the op_sub port exists and op_sub = 1 computes
//     op_a - op_b mod 2^WIDTH. In that case, carry = 1 means no borrow.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand pair offered
//   in_ready   out  1      operands can be accepted (IDLE only)
//   op_a       in   WIDTH  operand A, sampled on accept
//   op_b       in   WIDTH  operand B, sampled on accept
//   op_sub     in   1      subtract select, sampled on accept (SUB_EN only)
//   out_valid  out  1      result available (DONE only)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result
//   carry      out  1      carry out of the top nibble
//   busy       out  1      high in RUN or DONE
//
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int NIW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [NIW-1:0] LAST = NIW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NIW-1:0]   nib_idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_sel;
  logic             accept;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       nib_res;

  // 5-bit nibble add: {carry_out, sum_nibble}
  function automatic logic [4:0] nib_add(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       cin);
    return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  endfunction

`ifdef SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  // in_ready is forced low while reset is asserted, even if the state
  // register has not yet returned to IDLE.
  assign in_ready = rst_n && (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

  assign a_nib   = a_reg[{nib_idx, 2'b00} +: 4];
  assign b_nib   = b_reg[{nib_idx, 2'b00} +: 4];
  assign nib_res = nib_add(a_nib, b_nib, carry_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)             state_nxt = S_RUN;
      S_RUN:   if (nib_idx == LAST)    state_nxt = S_DONE;
      S_DONE:  if (out_ready)          state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  // Operand capture. For subtraction, B is stored inverted and the carry
  // chain starts at 1, giving A + ~B + 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= op_a;
      b_reg <= op_b ^ {WIDTH{sub_sel}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nib_idx   <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            nib_idx   <= '0;
            carry_reg <= sub_sel;
            sum       <= '0;
          end
        end
        S_RUN: begin
          sum[{nib_idx, 2'b00} +: 4] <= nib_res[3:0];
          carry_reg                  <= nib_res[4];
          nib_idx                    <= nib_idx + 1'b1;
          if (nib_idx == LAST) begin
            carry     <= nib_res[4];
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
